// File: rtl/fp_reg_file.sv
// FP register file ($f0..$f(NREGS-1)) with single/double operand formatting,
// same-edge write-to-read forwarding per 32-bit word, and the FP condition flag.
module fp_reg_file #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic          rd_dbl,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          wr_en,
  input  logic          wr_dbl,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic          cc_wr,
  input  logic          cc_in,
  output logic [63:0]   out1,
  output logic [63:0]   out2,
  output logic          cc_out,
  output logic          align_err
);

  logic [31:0]      regs    [NREGS];
  logic [31:0]      word_wd [NREGS];
  logic [31:0]      fwd     [NREGS];
  logic [NREGS-1:0] word_we;
  logic [AW-1:0]    raddr   [2];
  logic [63:0]      op      [2];
  logic             wr_mis;
  logic             wr_ok;
  logic             rd_mis;

  assign wr_mis = wr_en & wr_dbl & wr_addr[0];
  assign wr_ok  = wr_en & ~wr_mis;
  assign rd_mis = rd_en & rd_dbl & (rs_addr[0] | rt_addr[0]);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_word
      localparam logic [AW-1:0] IDX = AW'(gi);

      // A double write hits both words of the even/odd pair; even word takes the low half.
      assign word_we[gi] = wr_ok & (wr_dbl ? (wr_addr[AW-1:1] == IDX[AW-1:1])
                                           : (wr_addr == IDX));
      assign word_wd[gi] = (wr_dbl && !IDX[0]) ? wr_data[31:0] : wr_data[63:32];
      assign fwd[gi]     = word_we[gi] ? word_wd[gi] : regs[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs[gi] <= 32'h0;
        end else if (word_we[gi]) begin
          regs[gi] <= word_wd[gi];
        end
      end
    end
  endgenerate

  assign raddr[0] = rs_addr;
  assign raddr[1] = rt_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [AW-1:0] hi_addr;
      assign hi_addr = {raddr[gi][AW-1:1], 1'b1};
      // Reading through fwd gives per-word bypass of a same-edge write.
      assign op[gi] = !rd_dbl      ? {fwd[raddr[gi]], 32'h0} :
                      raddr[gi][0] ? 64'h0 :
                                     {fwd[hi_addr], fwd[raddr[gi]]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out1      <= 64'h0;
      out2      <= 64'h0;
      cc_out    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (rd_en) begin
        out1 <= op[0];
        out2 <= op[1];
      end
      if (cc_wr) begin
        cc_out <= cc_in;
      end
      align_err <= wr_mis | rd_mis;
    end
  end

endmodule

// File: tb/tb_fp_reg_file.sv
// Directed bench for fp_reg_file: a read-after-write register model checked every
// cycle, plus hand-computed literal checks on the key transactions.
module tb_fp_reg_file;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef bit [31:0] regs_t [NREGS];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_en, rd_dbl, wr_en, wr_dbl, cc_wr, cc_in;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr;
  logic [63:0]   wr_data;
  logic [63:0]   out1, out2;
  logic          cc_out, align_err;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  fp_reg_file #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_dbl(rd_dbl),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_en(wr_en), .wr_dbl(wr_dbl),
    .wr_addr(wr_addr), .wr_data(wr_data), .cc_wr(cc_wr), .cc_in(cc_in),
    .out1(out1), .out2(out2), .cc_out(cc_out), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  regs_t    m_regs;
  bit [63:0] m_out1, m_out2;
  bit        m_cc, m_ae;

  function automatic bit [63:0] fmt(regs_t r, int a, bit dbl);
    if (!dbl) return {r[a], 32'h0};
    if (a % 2 == 1) return 64'h0;
    return {r[a + 1], r[a]};
  endfunction

  // A read at an edge sees the register file as it stands after that edge's write.
  always @(posedge clk or posedge reset) begin
    regs_t nr;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] <= 32'h0;
      m_out1 <= 64'h0;
      m_out2 <= 64'h0;
      m_cc   <= 1'b0;
      m_ae   <= 1'b0;
    end else begin
      nr = m_regs;
      if (wr_en) begin
        if (!wr_dbl) begin
          nr[int'(wr_addr)] = wr_data[63:32];
        end else if (wr_addr % 2 == 0) begin
          nr[int'(wr_addr)]     = wr_data[31:0];
          nr[int'(wr_addr) + 1] = wr_data[63:32];
        end
      end
      m_regs <= nr;
      if (rd_en) begin
        m_out1 <= fmt(nr, int'(rs_addr), rd_dbl);
        m_out2 <= fmt(nr, int'(rt_addr), rd_dbl);
      end
      if (cc_wr) m_cc <= cc_in;
      m_ae <= (wr_en && wr_dbl && wr_addr % 2 == 1) ||
              (rd_en && rd_dbl && (rs_addr % 2 == 1 || rt_addr % 2 == 1));
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model.out1", out1, m_out1);
      check("model.out2", out2, m_out2);
      check("model.cc_out", {63'h0, cc_out}, {63'h0, m_cc});
      check("model.align_err", {63'h0, align_err}, {63'h0, m_ae});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_en = 0; rd_dbl = 0; rs_addr = '0; rt_addr = '0;
    wr_en = 0; wr_dbl = 0; wr_addr = '0; wr_data = '0;
    cc_wr = 0; cc_in = 0;
  endtask

  task automatic set_wr(bit dbl, int a, logic [63:0] d);
    wr_en = 1; wr_dbl = dbl; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic set_rd(bit dbl, int rs, int rt);
    rd_en = 1; rd_dbl = dbl; rs_addr = AW'(rs); rt_addr = AW'(rt);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    $display("[%0t] %s: out1=%h out2=%h cc=%b ae=%b", $time, tag, out1, out2, cc_out, align_err);
    idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle();
    #2 reset = 1'b1;
    #1;
    chk_en = 1'b1;
    check("reset.out1", out1, 64'h0);
    check("reset.out2", out2, 64'h0);
    check("reset.cc", {63'h0, cc_out}, 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // singles; low word of wr_data must be ignored
    set_wr(0, 2, 64'h3FA00000_DEADBEEF);   step("wr s f2");
    set_wr(0, 4, 64'h3F900000_12345678);   step("wr s f4");
    set_rd(0, 2, 4);                       step("rd s 2,4");
    check("rd_single.out1", out1, 64'h3FA00000_00000000);
    check("rd_single.out2", out2, 64'h3F900000_00000000);

    // double pair and its halves
    set_wr(1, 6, 64'h40109E66_60F0B59C);   step("wr d f6");
    set_rd(1, 6, 6);                       step("rd d 6");
    check("rd_double.out1", out1, 64'h40109E66_60F0B59C);
    set_rd(0, 7, 6);                       step("rd s 7,6");
    check("rd_hi_word.out1", out1, 64'h40109E66_00000000);
    check("rd_lo_word.out2", out2, 64'h60F0B59C_00000000);
    rs_addr = AW'(2);                      step("hold");
    check("hold.out1", out1, 64'h40109E66_00000000);

    // bypass
    set_wr(1, 8, 64'h0);                   step("wr d f8=0");
    set_wr(1, 8, 64'hC0B1D17C_D10164DA);
    set_rd(1, 8, 8);                       step("wr+rd d f8");
    check("bypass_dbl.out1", out1, 64'hC0B1D17C_D10164DA);
    check("bypass_dbl.out2", out2, 64'hC0B1D17C_D10164DA);
    set_wr(0, 9, 64'h3F800000_00000000);
    set_rd(1, 8, 4);                       step("wr s f9 + rd d 8");
    check("bypass_half.out1", out1, 64'h3F800000_D10164DA);
    set_wr(0, 0, 64'h12345678_00000000);
    set_rd(0, 0, 9);                       step("wr s f0 + rd s 0,9");
    check("f0_bypass.out1", out1, 64'h12345678_00000000);
    check("f0_bypass.out2", out2, 64'h3F800000_00000000);

    // misalignment
    set_wr(1, 3, 64'hFFFFFFFF_EEEEEEEE);   step("wr d f3 (bad)");
    check("mis_wr.align_err", {63'h0, align_err}, 64'h1);
    set_rd(0, 3, 4);                       step("rd s 3,4");
    check("mis_wr.align_clear", {63'h0, align_err}, 64'h0);
    check("mis_wr.f3", out1, 64'h0);
    check("mis_wr.f4", out2, 64'h3F900000_00000000);
    set_rd(1, 5, 6);                       step("rd d 5,6 (bad)");
    check("mis_rd.out1", out1, 64'h0);
    check("mis_rd.out2", out2, 64'h40109E66_60F0B59C);
    check("mis_rd.align_err", {63'h0, align_err}, 64'h1);

    // condition flag
    cc_wr = 1; cc_in = 1;                  step("cc <= 1");
    check("cc.set", {63'h0, cc_out}, 64'h1);
    cc_wr = 0; cc_in = 0;                  step("cc hold");
    check("cc.hold", {63'h0, cc_out}, 64'h1);
    cc_wr = 1; cc_in = 0;
    set_wr(0, 10, 64'h40000000_00000000);
    set_rd(0, 10, 2);                      step("cc <= 0 + wr/rd f10");
    check("cc.clear", {63'h0, cc_out}, 64'h0);
    check("cc_combo.out1", out1, 64'h40000000_00000000);
    cc_wr = 1; cc_in = 1;                  step("cc <= 1");

    // asynchronous reset mid-cycle, with a write/read pending
    set_wr(1, 2, 64'hAAAAAAAA_BBBBBBBB);
    set_rd(1, 2, 6);
    #3 reset = 1'b1;
    #1;
    check("async_rst.out1", out1, 64'h0);
    check("async_rst.out2", out2, 64'h0);
    check("async_rst.cc", {63'h0, cc_out}, 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    idle();
    set_rd(0, 2, 6);                       step("rd s 2 after reset");
    check("post_rst.f2", out1, 64'h0);
    check("post_rst.f6", out2, 64'h0);
    step("idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_reg_file.md
Name: fp_reg_file

Overview:
Floating-point register file and condition-flag register for the modified MIPS FP datapath. It sits directly upstream of fALU and supplies its 64-bit in1/in2 operands in single or double format. It also captures fALU's 1-bit compare result (con) into the FP condition flag used by FP branches. Each single read is 1-cycle registered, with write-to-read bypass.

Parameters:
NREGS, 32, number of 32-bit FP registers ($f0..$f31); must be even
AW, 5, register address width; log2(NREGS)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
rd_en  input  1  read strobe; operands update only when high
rd_dbl  input  1  0 = single-precision read, 1 = double-precision read
rs_addr  input  AW  source register for out1
rt_addr  input  AW  source register for out2
wr_en  input  1  write strobe
wr_dbl  input  1  0 = single write, 1 = double (pair) write
wr_addr  input  AW  destination register
wr_data  input  64  write data; single uses wr_data[63:32]
cc_wr  input  1  capture enable for condition flag
cc_in  input  1  compare result from fALU con
out1  output  64  operand A to fALU in1
out2  output  64  operand B to fALU in2
cc_out  output  1  FP condition flag
align_err  output  1  one-cycle pulse: misaligned double access

Behaviour:
- Reset (async, active-high): all NREGS registers = 0; out1 = out2 = 64'h0; cc_out = 0; align_err = 0. Reset asserted mid-operation discards any in-flight read or write in that cycle.
- Operand format: single = {reg[a], 32'h0}, with the value in bits [63:32] and the low word zero. Double = {reg[a+1], reg[a]}, where the even register holds the low word.
- Write, at a clock edge with wr_en=1:
  - Single: reg[wr_addr] <= wr_data[63:32].
  - Double: reg[wr_addr] <= wr_data[31:0]; reg[wr_addr+1] <= wr_data[63:32].
  - $f0 is an ordinary writable register (no hardwired zero).
- Read, at a clock edge with rd_en=1: out1/out2 load the formatted operands for rs_addr/rt_addr. Latency is 1 cycle.
- Read hold: with rd_en=0, out1/out2 hold their previous values.
- Bypass: a same-edge write to any 32-bit word being read forwards the new data into out1/out2. Rules:
  - Compare per word, not per access, so a single write into half of a double read updates only that half.
  - Bypass applies independently to rs and rt. If rs == rt, out1 == out2.
- Misalignment: a double access with an odd address is illegal.
  - Write (wr_en & wr_dbl & wr_addr[0]): the write is suppressed and no register changes.
  - Read (rd_en & rd_dbl & (rs_addr[0] | rt_addr[0])): the offending operand loads 64'h0; the other operand loads normally.
  - Either case drives align_err = 1 for exactly the next cycle; otherwise align_err = 0.
- Condition flag: cc_wr=1 at an edge sets cc_out <= cc_in, otherwise cc_out holds. It is independent of the register writes. Any combination of cc_wr, wr_en and rd_en in the same cycle is legal and all take effect.
- Regfile write and read may target the same, overlapping or disjoint registers in the same cycle; only the bypass rule governs the result.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Single write $f2 <= 3FA00000, $f4 <= 3F900000; next cycle read single rs=2, rt=4 -> out1=3FA00000_00000000, out2=3F900000_00000000 one cycle after rd_en.
- Double write $f6 <= 40109E6660F0B59C; read double rs=6 -> out1=40109E6660F0B59C; read single rs=7 -> 40109E66_00000000; read single rs=6 -> 60F0B59C_00000000.
- Bypass: preload $f8/$f9 with 0. Same edge: double write $f8 <= C0B1D17CD10164DA and double read rs=rt=8 -> out1=out2=C0B1D17CD10164DA. Then single write $f9 <= 3F800000 with double read rs=8 -> out1=3F800000_D10164DA.
- Misaligned: double write wr_addr=3 -> $f3/$f4 unchanged, align_err high 1 cycle. Double read rs=5, rt=6 -> out1=0, out2=pair(6), align_err pulses.
- Condition flag: cc_wr=1, cc_in=1 -> cc_out=1 next cycle. cc_wr=0, cc_in=0 -> cc_out stays 1. cc_wr=1, cc_in=0 -> cc_out=0.
- Reset mid-operation: after the above, assert reset asynchronously between edges -> out1=out2=0, cc_out=0 immediately. After release, single read of $f2 -> 00000000_00000000.
